// File: rtl/vram_port_arbiter.sv
// CPU-side PPU register block (PPUCTRL increment, PPUSTATUS latch reset, PPUADDR, PPUDATA)
// sharing VRAM port A with a boot loader; the CPU always wins arbitration.
module vram_port_arbiter #(
    parameter int INC_BIT = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mirror,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_reg,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    input  logic        ld_req,
    input  logic [10:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ack,
    output logic [10:0] vram_address,
    output logic [7:0]  vram_i_data,
    output logic        vram_writena,
    input  logic [7:0]  vram_o_data
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR      = 2'd1;
    localparam logic [1:0] RD_ADDR = 2'd2;
    localparam logic [1:0] RD_CAP  = 2'd3;

    logic [1:0]  state_reg;
    logic [13:0] v_reg;
    logic        w_reg;
    logic        inc32_reg;
    logic [7:0]  rbuf_reg;
    logic        rd_mapped_reg;

    logic        v_mapped;
    logic [10:0] phys_addr;
    logic [13:0] v_step;

    assign v_mapped  = (v_reg >= 14'h2000) && (v_reg <= 14'h3EFF);
    assign phys_addr = mirror ? {v_reg[10], v_reg[9:0]} : {v_reg[11], v_reg[9:0]};
    assign v_step    = inc32_reg ? 14'd32 : 14'd1;
    assign cpu_ready = (state_reg == IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            v_reg         <= 14'h0000;
            w_reg         <= 1'b0;
            inc32_reg     <= 1'b0;
            rbuf_reg      <= 8'h00;
            rd_mapped_reg <= 1'b0;
            cpu_rdata     <= 8'h00;
            ld_ack        <= 1'b0;
            vram_address  <= 11'h000;
            vram_i_data   <= 8'h00;
            vram_writena  <= 1'b0;
        end else begin
            // Write strobes are single-cycle pulses unless re-armed below.
            vram_writena <= 1'b0;
            ld_ack       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cpu_req) begin
                        // Reads of registers without a defined read value return zero.
                        if (!cpu_we) begin
                            cpu_rdata <= 8'h00;
                        end
                        case (cpu_reg)
                            3'd0: begin
                                if (cpu_we) begin
                                    inc32_reg <= cpu_wdata[INC_BIT];
                                end
                            end
                            3'd2: begin
                                if (!cpu_we) begin
                                    w_reg <= 1'b0;
                                end
                            end
                            3'd6: begin
                                if (cpu_we) begin
                                    if (!w_reg) begin
                                        v_reg[13:8] <= cpu_wdata[5:0];
                                        w_reg       <= 1'b1;
                                    end else begin
                                        v_reg[7:0] <= cpu_wdata;
                                        w_reg      <= 1'b0;
                                    end
                                end
                            end
                            3'd7: begin
                                v_reg <= v_reg + v_step;
                                if (cpu_we) begin
                                    if (v_mapped) begin
                                        vram_address <= phys_addr;
                                        vram_i_data  <= cpu_wdata;
                                        vram_writena <= 1'b1;
                                    end
                                    state_reg <= WR;
                                end else begin
                                    // Reads return the buffer filled by the previous access.
                                    cpu_rdata     <= rbuf_reg;
                                    vram_address  <= phys_addr;
                                    rd_mapped_reg <= v_mapped;
                                    state_reg     <= RD_ADDR;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end else if (ld_req) begin
                        vram_address <= ld_addr;
                        vram_i_data  <= ld_data;
                        vram_writena <= 1'b1;
                        ld_ack       <= 1'b1;
                        state_reg    <= WR;
                    end
                end
                WR: begin
                    state_reg <= IDLE;
                end
                RD_ADDR: begin
                    state_reg <= RD_CAP;
                end
                RD_CAP: begin
                    rbuf_reg  <= rd_mapped_reg ? vram_o_data : 8'h00;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a 2K synchronous-read RAM model on port A.
module tb_vram_port_arbiter;

    logic        clock;
    logic        reset_n;
    logic        mirror;
    logic        cpu_req;
    logic        cpu_we;
    logic [2:0]  cpu_reg;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        ld_req;
    logic [10:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_ack;
    logic [10:0] vram_address;
    logic [7:0]  vram_i_data;
    logic        vram_writena;
    logic [7:0]  vram_o_data;

    int checks_total;
    int checks_passed;

    logic [7:0] mem [0:2047];

    vram_port_arbiter #(.INC_BIT(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .mirror       (mirror),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_reg      (cpu_reg),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .ld_req       (ld_req),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_ack       (ld_ack),
        .vram_address (vram_address),
        .vram_i_data  (vram_i_data),
        .vram_writena (vram_writena),
        .vram_o_data  (vram_o_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (vram_writena) begin
            mem[vram_address] <= vram_i_data;
        end
        vram_o_data <= mem[vram_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_op(input logic we, input logic [2:0] r, input logic [7:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_reg   = r;
        cpu_wdata = d;
        tick();
        cpu_req = 1'b0;
        $display("cpu %s $200%0d data=0x%02h -> rdata=0x%02h addr=0x%03h we=%0b",
                 we ? "wr" : "rd", r, d, cpu_rdata, vram_address, vram_writena);
    endtask

    task automatic set_v(input logic [7:0] hi, input logic [7:0] lo);
        cpu_op(1'b1, 3'd6, hi);
        cpu_op(1'b1, 3'd6, lo);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!cpu_ready && n < 8) begin
            tick();
            n++;
        end
        check(tag, {31'd0, cpu_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int first_ack;
        int ack_count;
        checks_total  = 0;
        checks_passed = 0;
        reset_n   = 1'b0;
        mirror    = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_reg   = 3'd0;
        cpu_wdata = 8'h00;
        ld_req    = 1'b0;
        ld_addr   = 11'h000;
        ld_data   = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", {31'd0, cpu_ready}, 32'd1);
        check("rst_we", {31'd0, vram_writena}, 32'd0);
        check("rst_ack", {31'd0, ld_ack}, 32'd0);
        check("rst_addr", {21'd0, vram_address}, 32'd0);
        check("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Loader preloads RAM[0x010] = 0x77.
        ld_req  = 1'b1;
        ld_addr = 11'h010;
        ld_data = 8'h77;
        tick();
        $display("ld wr addr=0x%03h data=0x%02h ack=%0b", ld_addr, ld_data, ld_ack);
        check("ld_ack", {31'd0, ld_ack}, 32'd1);
        check("ld_addr", {21'd0, vram_address}, 32'h010);
        check("ld_data", {24'd0, vram_i_data}, 32'h77);
        check("ld_we", {31'd0, vram_writena}, 32'd1);
        ld_req = 1'b0;
        tick();
        check("ld_we_drop", {31'd0, vram_writena}, 32'd0);
        check("ld_ack_drop", {31'd0, ld_ack}, 32'd0);

        // v = 0x2108, vertical mirroring.
        mirror = 1'b1;
        set_v(8'h21, 8'h08);
        cpu_op(1'b1, 3'd7, 8'hAB);
        check("w7_addr", {21'd0, vram_address}, 32'h108);
        check("w7_data", {24'd0, vram_i_data}, 32'hAB);
        check("w7_we", {31'd0, vram_writena}, 32'd1);
        check("w7_busy", {31'd0, cpu_ready}, 32'd0);
        tick();
        check("w7_we_single", {31'd0, vram_writena}, 32'd0);
        check("w7_ready", {31'd0, cpu_ready}, 32'd1);
        cpu_op(1'b1, 3'd7, 8'hCD);
        check("w7_inc1", {21'd0, vram_address}, 32'h109);
        wait_ready("w7_inc1_ready");

        // Mirroring of v = 0x2400.
        mirror = 1'b0;
        set_v(8'h24, 8'h00);
        cpu_op(1'b1, 3'd7, 8'h5A);
        check("mir_h", {21'd0, vram_address}, 32'h000);
        wait_ready("mir_h_ready");
        mirror = 1'b1;
        set_v(8'h24, 8'h00);
        cpu_op(1'b1, 3'd7, 8'h5A);
        check("mir_v", {21'd0, vram_address}, 32'h400);
        wait_ready("mir_v_ready");

        // Delayed read buffer at v = 0x2010.
        set_v(8'h20, 8'h10);
        cpu_op(1'b0, 3'd7, 8'h00);
        check("rd1_data", {24'd0, cpu_rdata}, 32'h00);
        check("rd1_addr", {21'd0, vram_address}, 32'h010);
        check("rd1_busy0", {31'd0, cpu_ready}, 32'd0);
        tick();
        check("rd1_busy1", {31'd0, cpu_ready}, 32'd0);
        tick();
        check("rd1_ready", {31'd0, cpu_ready}, 32'd1);
        cpu_op(1'b0, 3'd7, 8'h00);
        check("rd2_data", {24'd0, cpu_rdata}, 32'h77);
        check("rd2_addr", {21'd0, vram_address}, 32'h011);
        wait_ready("rd2_ready");
        cpu_op(1'b0, 3'd2, 8'h00);
        check("status_rd", {24'd0, cpu_rdata}, 32'h00);

        // Increment by 32, unmapped accesses and wrap.
        cpu_op(1'b1, 3'd0, 8'h04);
        set_v(8'h3F, 8'hF0);
        cpu_op(1'b1, 3'd7, 8'h99);
        check("unmap_drop", {31'd0, vram_writena}, 32'd0);
        wait_ready("unmap_ready");
        cpu_op(1'b0, 3'd7, 8'h00);
        check("wrap_v0010", {21'd0, vram_address}, 32'h010);
        wait_ready("unmap_rd_ready");
        cpu_op(1'b0, 3'd7, 8'h00);
        check("unmap_rbuf", {24'd0, cpu_rdata}, 32'h00);
        check("inc32_v0030", {21'd0, vram_address}, 32'h030);
        wait_ready("unmap_rd2_ready");
        set_v(8'h3F, 8'hFF);
        cpu_op(1'b1, 3'd7, 8'h00);
        wait_ready("wrap_wr_ready");
        cpu_op(1'b0, 3'd7, 8'h00);
        check("wrap_v001f", {21'd0, vram_address}, 32'h01F);
        wait_ready("wrap_rd_ready");
        cpu_op(1'b1, 3'd0, 8'h00);

        // CPU and loader request in the same cycle.
        set_v(8'h20, 8'h40);
        ld_req  = 1'b1;
        ld_addr = 11'h123;
        ld_data = 8'h3C;
        cpu_op(1'b1, 3'd7, 8'h11);
        check("arb_cpu_addr", {21'd0, vram_address}, 32'h040);
        check("arb_cpu_data", {24'd0, vram_i_data}, 32'h11);
        check("arb_no_ack", {31'd0, ld_ack}, 32'd0);
        first_ack = -1;
        ack_count = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (ld_ack) begin
                ack_count++;
                if (first_ack < 0) begin
                    first_ack = i;
                    $display("ld wr addr=0x%03h data=0x%02h ack=1 cycle=%0d", vram_address, vram_i_data, i);
                    check("arb_ld_addr", {21'd0, vram_address}, 32'h123);
                    check("arb_ld_data", {24'd0, vram_i_data}, 32'h3C);
                    ld_req = 1'b0;
                end
            end
        end
        ld_req = 1'b0;
        check("arb_ack_count", ack_count, 32'd1);
        check("arb_ack_late", {31'd0, first_ack >= 2}, 32'd1);

        // Asynchronous reset while a write is on the port.
        mirror = 1'b0;
        cpu_op(1'b1, 3'd6, 8'h3F);
        cpu_op(1'b0, 3'd2, 8'h00);
        check("w_clear_rdata", {24'd0, cpu_rdata}, 32'h00);
        set_v(8'h23, 8'h00);
        cpu_op(1'b1, 3'd7, 8'hEE);
        check("pre_rst_addr", {21'd0, vram_address}, 32'h300);
        check("pre_rst_we", {31'd0, vram_writena}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_we", {31'd0, vram_writena}, 32'd0);
        check("arst_ack", {31'd0, ld_ack}, 32'd0);
        check("arst_ready", {31'd0, cpu_ready}, 32'd1);
        check("arst_addr", {21'd0, vram_address}, 32'd0);
        check("arst_data", {24'd0, vram_i_data}, 32'd0);
        check("arst_rdata", {24'd0, cpu_rdata}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        set_v(8'h21, 8'h40);
        cpu_op(1'b1, 3'd7, 8'h55);
        check("post_rst_addr", {21'd0, vram_address}, 32'h140);
        check("post_rst_we", {31'd0, vram_writena}, 32'd1);
        wait_ready("post_rst_ready");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
